// File: rtl/rd_align_pipe.sv
// Pairs each RAM read address with its returned data, then delays the beat by 0..MAX_DLY stages.
// Latency: RAM_LAT + 1 + dly_q advancing cycles from address to o_R_VALID; outputs are flop-driven.
// No backpressure: i_en is a shared clock-enable that freezes the whole pipe; i_flush drops all beats.
module rd_align_pipe #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1,
    parameter int MAX_DLY = 4,
    parameter int DLY_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic [DLY_W-1:0]  i_dly_sel,
    input  logic              i_R_VALID,
    input  logic [ADDR_W-1:0] i_R_ADDR,
    input  logic [DATA_W-1:0] i_R_DATA,
    output logic              o_R_VALID,
    output logic [ADDR_W-1:0] o_R_ADDR,
    output logic [DATA_W-1:0] o_R_DATA,
    output logic              o_dly_err,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_cnt
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
    } ap_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } beat_t;

    ap_t              ap_q [RAM_LAT];
    ap_t              ap_d [RAM_LAT];
    beat_t            dl_q [MAX_DLY+1];
    beat_t            dl_d [MAX_DLY+1];
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;
    logic             dly_load;
    logic             dly_over;

    // Any valid bit in either pipe, including stages past the selected tap, so a
    // delay change can never re-expose a beat that has already been emitted.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < RAM_LAT; k++) busy = busy | ap_q[k].vld;
        for (int k = 0; k <= MAX_DLY; k++) busy = busy | dl_q[k].vld;
    end

    // Address pipe and delay line shift together on i_en; flush wins and kills every valid.
    always_comb begin
        ap_d = ap_q;
        dl_d = dl_q;
        if (i_en) begin
            ap_d[0].vld  = i_R_VALID;
            ap_d[0].addr = i_R_ADDR;
            for (int k = 1; k < RAM_LAT; k++) ap_d[k] = ap_q[k-1];
            dl_d[0].vld  = ap_q[RAM_LAT-1].vld;
            dl_d[0].addr = ap_q[RAM_LAT-1].addr;
            dl_d[0].dat  = i_R_DATA;
            for (int k = 1; k <= MAX_DLY; k++) dl_d[k] = dl_q[k-1];
        end
        if (i_flush) begin
            for (int k = 0; k < RAM_LAT; k++) ap_d[k].vld = 1'b0;
            for (int k = 0; k <= MAX_DLY; k++) dl_d[k].vld = 1'b0;
        end
    end

    // Delay tap only moves when nothing is in flight (or everything is being flushed),
    // out-of-range requests clamp to the deepest tap and raise the sticky error.
    always_comb begin
        dly_over = (i_dly_sel > DLY_W'(MAX_DLY));
        dly_load = !busy || i_flush;
        dly_d    = dly_q;
        err_d    = err_q;
        if (dly_load) begin
            dly_d = dly_over ? DLY_W'(MAX_DLY) : i_dly_sel;
            err_d = err_q | dly_over;
        end
    end

    // Count beats that become visible at the output tap on an advancing edge; wraps freely.
    always_comb begin
        cnt_d = cnt_q;
        if (i_en && dl_d[dly_d].vld) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers; async reset clears everything so outputs drop immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RAM_LAT; k++) ap_q[k] <= '0;
            for (int k = 0; k <= MAX_DLY; k++) dl_q[k] <= '0;
            dly_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ap_q  <= ap_d;
            dl_q  <= dl_d;
            dly_q <= dly_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_R_VALID = dl_q[dly_q].vld;
    assign o_R_ADDR  = dl_q[dly_q].addr;
    assign o_R_DATA  = dl_q[dly_q].dat;
    assign o_dly_err = err_q;
    assign o_busy    = busy;
    assign o_cnt     = cnt_q;

endmodule

// File: tb/tb_rd_align_pipe.sv
module tb_rd_align_pipe;

    localparam int RAM_LAT = 1;
    localparam int MAX_DLY = 4;
    localparam int LIM     = RAM_LAT + MAX_DLY;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, flush = 1'b0, vld_i = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [13:0] addr_i = '0;
    logic [7:0]  data_i;
    logic [13:0] ram_addr = '0;

    logic        o_vld, o_err, o_busy;
    logic [13:0] o_addr;
    logic [7:0]  o_data;
    logic [15:0] o_cnt;
    logic        o_vld4, o_err4, o_busy4;
    logic [13:0] o_addr4;
    logic [7:0]  o_data4;
    logic [3:0]  o_cnt4;

    int npass = 0;
    int nchk  = 0;

    rd_align_pipe dut (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_flush(flush), .i_dly_sel(sel),
        .i_R_VALID(vld_i), .i_R_ADDR(addr_i), .i_R_DATA(data_i),
        .o_R_VALID(o_vld), .o_R_ADDR(o_addr), .o_R_DATA(o_data),
        .o_dly_err(o_err), .o_busy(o_busy), .o_cnt(o_cnt)
    );

    rd_align_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_flush(flush), .i_dly_sel(sel),
        .i_R_VALID(vld_i), .i_R_ADDR(addr_i), .i_R_DATA(data_i),
        .o_R_VALID(o_vld4), .o_R_ADDR(o_addr4), .o_R_DATA(o_data4),
        .o_dly_err(o_err4), .o_busy(o_busy4), .o_cnt(o_cnt4)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency sharing the pipe's clock-enable.
    function automatic logic [7:0] ram(input logic [13:0] a);
        return a[7:0] ^ 8'hB0;
    endfunction
    always @(posedge clk) if (en) ram_addr <= addr_i;
    assign data_i = ram(ram_addr);

    // Reference model: beats tagged with the advancing-edge index at which they entered.
    typedef struct { int t; logic [13:0] a; } mb_t;
    mb_t         q[$];
    int          m_T = 0;
    int          m_D = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_cnt = '0;
    logic        m_vld = 1'b0, m_busy = 1'b0;
    logic [13:0] m_addr = '0;
    logic [7:0]  m_data = '0;

    function automatic void model_out();
        while (q.size() > 0 && (m_T - q[0].t) > LIM) void'(q.pop_front());
        m_vld  = 1'b0;
        m_busy = (q.size() > 0);
        foreach (q[i]) begin
            if (q[i].t == m_T - RAM_LAT - m_D) begin
                m_vld  = 1'b1;
                m_addr = q[i].a;
                m_data = ram(q[i].a);
            end
        end
    endfunction

    function automatic void model_edge(input logic e, input logic f, input logic v,
                                       input logic [13:0] a, input logic [2:0] s);
        if (f || !m_busy) begin
            m_D = (s > 3'(MAX_DLY)) ? MAX_DLY : int'(s);
            if (s > 3'(MAX_DLY)) m_err = 1'b1;
        end
        if (f) q.delete();
        else if (e) begin
            m_T++;
            if (v) q.push_back('{m_T, a});
        end
        model_out();
        if (e && !f && m_vld) m_cnt++;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_T = 0; m_D = 0; m_err = 1'b0; m_cnt = '0;
        model_out();
    endfunction

    task automatic cyc(input logic e, input logic f, input logic v,
                       input logic [13:0] a, input logic [2:0] s);
        en = e; flush = f; vld_i = v; addr_i = a; sel = s;
        @(posedge clk);
        model_edge(e, f, v, a, s);
        #1;
    endtask

    task automatic do_reset();
        en = 0; flush = 0; vld_i = 0; addr_i = '0; sel = 3'd0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); flush = 1'($urandom); vld_i = 1'($urandom);
            addr_i = 14'($urandom); sel = 3'($urandom);
            @(posedge clk); #1;
            nchk++;
            if ({o_vld, o_addr, o_data, o_err, o_busy, o_cnt} !== '0 ||
                {o_vld4, o_addr4, o_data4, o_err4, o_busy4, o_cnt4} !== '0) begin
                $display("FAIL reset_state: got vld=%b addr=%h data=%h err=%b busy=%b cnt=%0d cnt4=%0d, want all 0",
                         o_vld, o_addr, o_data, o_err, o_busy, o_cnt, o_cnt4);
            end else npass++;
        end
        en = 0; flush = 0; vld_i = 0; sel = 3'd0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, '0, 3'd0);
            nchk++;
            if (o_vld !== 1'b0 || o_cnt !== 16'd0 || o_busy !== 1'b0) begin
                $display("FAIL reset_idle: vld=%b cnt=%0d busy=%b want 0/0/0", o_vld, o_cnt, o_busy);
            end else npass++;
        end
    endtask

    task automatic test_align();
        logic exp_v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, (i < 4), 14'h0010 + 14'(i < 4 ? i : 0), 3'd0);
            exp_v = (i >= 1 && i <= 4);
            nchk++;
            if (o_vld !== exp_v || (exp_v && (o_addr !== 14'h0010 + 14'(i-1) || o_data !== 8'hA0 + 8'(i-1)))) begin
                $display("FAIL align_pair edge%0d: vld=%b addr=%h data=%h want vld=%b addr=%h data=%h",
                         i, o_vld, o_addr, o_data, exp_v, 14'h0010 + 14'(i-1), 8'hA0 + 8'(i-1));
            end else npass++;
        end
        nchk++;
        if (o_cnt !== 16'd4) $display("FAIL align_cnt: cnt=%0d want 4", o_cnt);
        else npass++;
    endtask

    // Stream table driven through the model, one combined comparison per cycle.
    task automatic test_delay();
        for (int i = 0; i < 22; i++) begin
            if (i < 16) cyc(1, 0, (i >= 1 && i <= 4), 14'h0010 + 14'(i-1), 3'd3);
            else        cyc(1, 0, (i == 18), 14'h0123, 3'd7);
            nchk++;
            if (o_vld !== m_vld || o_vld4 !== m_vld || (m_vld && (o_addr !== m_addr || o_data !== m_data)) ||
                o_busy !== m_busy || o_err !== m_err || o_cnt !== m_cnt[15:0] || o_cnt4 !== m_cnt[3:0]) begin
                $display("FAIL delay3 i=%0d: vld=%b/%b addr=%h/%h data=%h/%h busy=%b/%b err=%b/%b cnt=%0d/%0d",
                         i, o_vld, m_vld, o_addr, m_addr, o_data, m_data, o_busy, m_busy, o_err, m_err, o_cnt, m_cnt[15:0]);
            end else npass++;
        end
        nchk++;
        if (o_err !== 1'b1) $display("FAIL dly_err_sticky: err=%b want 1", o_err);
        else npass++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(!(i == 3 || i == 4), 0, (i < 6 && !(i == 3 || i == 4)), 14'h0200 + 14'(i), 3'd1);
            nchk++;
            if (o_vld !== m_vld || o_vld4 !== m_vld || (m_vld && (o_addr !== m_addr || o_data !== m_data)) ||
                o_busy !== m_busy || o_err !== m_err || o_cnt !== m_cnt[15:0] || o_cnt4 !== m_cnt[3:0]) begin
                $display("FAIL stall i=%0d: vld=%b/%b addr=%h/%h data=%h/%h busy=%b/%b cnt=%0d/%0d",
                         i, o_vld, m_vld, o_addr, m_addr, o_data, m_data, o_busy, m_busy, o_cnt, m_cnt[15:0]);
            end else npass++;
        end
    endtask

    task automatic test_flush_dly();
        logic [2:0] s;
        logic       f, v;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            s = (i >= 2 && i < 12) || i >= 14 ? 3'd2 : 3'd0;
            if (i >= 12 && i < 14) s = 3'd0;
            f = (i == 16);
            v = (i <= 2) || (i == 14) || (i == 15) || (i == 18);
            cyc(1, f, v, 14'h0300 + 14'(i), s);
            nchk++;
            if (o_vld !== m_vld || o_vld4 !== m_vld || (m_vld && (o_addr !== m_addr || o_data !== m_data)) ||
                o_busy !== m_busy || o_err !== m_err || o_cnt !== m_cnt[15:0] || o_cnt4 !== m_cnt[3:0]) begin
                $display("FAIL flush_dly i=%0d: vld=%b/%b addr=%h/%h data=%h/%h busy=%b/%b cnt=%0d/%0d",
                         i, o_vld, m_vld, o_addr, m_addr, o_data, m_data, o_busy, m_busy, o_cnt, m_cnt[15:0]);
            end else npass++;
            if (i == 16) begin
                nchk++;
                if (o_busy !== 1'b0 || o_vld !== 1'b0) $display("FAIL flush_empty: busy=%b vld=%b want 0/0", o_busy, o_vld);
                else npass++;
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] s = 3'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) s = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
                14'($urandom), s);
            nchk++;
            if (o_vld !== m_vld || o_vld4 !== m_vld || (m_vld && (o_addr !== m_addr || o_data !== m_data ||
                o_addr4 !== m_addr || o_data4 !== m_data)) || o_busy !== m_busy || o_busy4 !== m_busy ||
                o_err !== m_err || o_err4 !== m_err || o_cnt !== m_cnt[15:0] || o_cnt4 !== m_cnt[3:0]) begin
                $display("FAIL random i=%0d: vld=%b/%b addr=%h/%h data=%h/%h busy=%b/%b err=%b/%b cnt=%0d/%0d cnt4=%0d/%0d",
                         i, o_vld, m_vld, o_addr, m_addr, o_data, m_data, o_busy, m_busy, o_err, m_err,
                         o_cnt, m_cnt[15:0], o_cnt4, m_cnt[3:0]);
            end else npass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cyc(1, 0, (i < 17), 14'h0400 + 14'(i), 3'd0);
            nchk++;
            if (o_vld !== m_vld || o_vld4 !== m_vld || (m_vld && (o_addr4 !== m_addr || o_data4 !== m_data)) ||
                o_cnt !== m_cnt[15:0] || o_cnt4 !== m_cnt[3:0]) begin
                $display("FAIL wrap i=%0d: vld=%b/%b cnt=%0d/%0d cnt4=%0d/%0d",
                         i, o_vld, m_vld, o_cnt, m_cnt[15:0], o_cnt4, m_cnt[3:0]);
            end else npass++;
        end
        nchk++;
        if (o_cnt4 !== 4'd1 || o_cnt !== 16'd17) $display("FAIL wrap_end: cnt4=%0d cnt=%0d want 1/17", o_cnt4, o_cnt);
        else npass++;
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 14'h0500 + 14'(i), 3'd0);
        nchk++;
        if (o_vld !== 1'b1) $display("FAIL pre_async_reset: vld=%b want 1", o_vld);
        else npass++;
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if (o_vld !== 1'b0 || o_vld4 !== 1'b0 || o_busy !== 1'b0 || o_cnt !== 16'd0)
            $display("FAIL async_reset: vld=%b vld4=%b busy=%b cnt=%0d want 0", o_vld, o_vld4, o_busy, o_cnt);
        else npass++;
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        en = 0; vld_i = 0;
    endtask

    initial begin
        test_reset();
        test_align();
        test_delay();
        test_stall();
        test_flush_dly();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
